// File: rtl/fir_output_fifo_if.sv
// Valid/ready stream bundle between the FIR filter, the output FIFO and the serializer.
// The slave modport is the FIFO; the master modport is whatever drives both stream sides.
interface fir_output_fifo_if #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 16
);
   logic                     i_en;
   logic [DATA_WIDTH-1:0]    iv_din;
   logic                     i_din_valid;
   logic                     o_ready;
   logic [DATA_WIDTH-1:0]    ov_dout;
   logic                     o_dout_valid;
   logic                     i_ready;
   logic [$clog2(DEPTH):0]   o_count;
   logic                     o_almost_full;

   modport slave (
      input  i_en, iv_din, i_din_valid, i_ready,
      output o_ready, ov_dout, o_dout_valid, o_count, o_almost_full
   );

   modport master (
      output i_en, iv_din, i_din_valid, i_ready,
      input  o_ready, ov_dout, o_dout_valid, o_count, o_almost_full
   );
endinterface

// File: rtl/fir_output_fifo.sv
// First-word-fall-through FIFO buffering FIR output words for the serializer.
// Occupancy is tracked in a counter so full and empty never rely on pointer equality.
module fir_output_fifo #(
   parameter int DATA_WIDTH        = 24,
   parameter int DEPTH             = 16,
   parameter int ALMOST_FULL_LEVEL = 12
) (
   input  logic               i_clk,
   input  logic               i_rst,
   fir_output_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fir_output_fifo: DEPTH must be a power of two and at least 2");
   end
   if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_af
      $error("fir_output_fifo: ALMOST_FULL_LEVEL must be in 1..DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  not_full;
   logic                  not_empty;
   logic                  ready;
   logic                  dout_valid;
   logic                  wr_fire;
   logic                  rd_fire;

   // Handshake flags depend only on registered occupancy, enable and reset,
   // never on the partner's valid/ready, so no combinational loop can form.
   assign not_full   = (count != CW'(DEPTH));
   assign not_empty  = (count != '0);
   assign ready      = bus.i_en & ~i_rst & not_full;
   assign dout_valid = bus.i_en & not_empty;
   assign wr_fire    = bus.i_din_valid & ready;
   assign rd_fire    = dout_valid & bus.i_ready;

   // NOTE: storage has no reset; its contents are don't-care until written and
   // leaving it out of the reset tree lets it map onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (wr_fire) begin
         mem[wr_ptr] <= bus.iv_din;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_fire, rd_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Head word comes straight from the RAM head; forced to zero when nothing is
   // held so reset and empty present a clean bus instead of stale storage.
   assign bus.ov_dout       = not_empty ? mem[rd_ptr] : '0;
   assign bus.o_dout_valid  = dout_valid;
   assign bus.o_ready       = ready;
   assign bus.o_count       = count;
   assign bus.o_almost_full = (count >= CW'(ALMOST_FULL_LEVEL));
endmodule

// File: tb/tb_fir_output_fifo.sv
// Self-checking bench for fir_output_fifo: vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_fir_output_fifo;
   localparam int DW    = 24;
   localparam int DEPTH = 16;
   localparam int AFL   = 12;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   always #5 i_clk = ~i_clk;

   fir_output_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   fir_output_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] model_q [$];
   logic [DW-1:0] out_log [$];

   typedef struct {
      logic          en;
      logic          dv;
      logic [DW-1:0] din;
      logic          rdy;
      int            cnt;
      logic          vld;
      logic          chk_dout;
      logic [DW-1:0] dout;
      logic          rdy_o;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic en, input logic dv, input logic [DW-1:0] din, input logic rdy);
      bus.i_en        = en;
      bus.i_din_valid = dv;
      bus.iv_din      = din;
      bus.i_ready     = rdy;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b1, 24'h5A5A5A, 1'b1);
      i_rst = 1'b1;
      #1;
      check("rst_ready", 32'(bus.o_ready), 32'd0);
      repeat (3) @(posedge i_clk);
      #2;
      check("rst_count", 32'(bus.o_count), 32'd0);
      check("rst_valid", 32'(bus.o_dout_valid), 32'd0);
      check("rst_dout", 32'(bus.ov_dout), 32'd0);
      check("rst_af", 32'(bus.o_almost_full), 32'd0);
      check("rst_ready_hold", 32'(bus.o_ready), 32'd0);
      i_rst = 1'b0;
      drive(1'b1, 1'b0, '0, 1'b0);
      model_q.delete();
      out_log.delete();
      #1;
      check("post_rst_ready", 32'(bus.o_ready), 32'd1);
      check("post_rst_count", 32'(bus.o_count), 32'd0);
   endtask

   // One clock cycle of traffic, checked against the queue model before and after the edge.
   task automatic cyc(input logic en, input logic dv, input logic [DW-1:0] din, input logic rdy);
      logic exp_ready, exp_valid, wr, rd;
      drive(en, dv, din, rdy);
      #1;
      exp_ready = en && (model_q.size() < DEPTH);
      exp_valid = en && (model_q.size() > 0);
      check("ready", 32'(bus.o_ready), 32'(exp_ready));
      check("valid", 32'(bus.o_dout_valid), 32'(exp_valid));
      if (model_q.size() > 0) check("dout", 32'(bus.ov_dout), 32'(model_q[0]));
      wr = dv && exp_ready;
      rd = exp_valid && rdy;
      if (rd) out_log.push_back(bus.ov_dout);
      @(posedge i_clk);
      if (rd) void'(model_q.pop_front());
      if (wr) model_q.push_back(din);
      #1;
      check("count", 32'(bus.o_count), 32'(model_q.size()));
      check("almost_full", 32'(bus.o_almost_full), 32'(model_q.size() >= AFL));
   endtask

   initial begin
      // en dv din rdy | cnt vld chk dout rdy_o (outputs observed after the edge)
      vecs[0] = '{1'b1, 1'b1, 24'hABCDEF, 1'b0, 1, 1'b1, 1'b1, 24'hABCDEF, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1, 1'b1, 1'b1, 24'hABCDEF, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 24'h123456, 1'b1, 1, 1'b0, 1'b1, 24'hABCDEF, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 24'h123456, 1'b1, 1, 1'b0, 1'b1, 24'hABCDEF, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 24'h000000, 1'b1, 0, 1'b0, 1'b0, 24'h000000, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 24'h000111, 1'b1, 1, 1'b1, 1'b1, 24'h000111, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 24'h000222, 1'b1, 1, 1'b1, 1'b1, 24'h000222, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 24'h000000, 1'b1, 0, 1'b0, 1'b0, 24'h000000, 1'b1};

      drive(1'b0, 1'b0, '0, 1'b0);
      @(posedge i_clk);
      #1;

      // Reset then the vector table: single word, enable freeze, empty and count-1 corners
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].en, vecs[i].dv, vecs[i].din, vecs[i].rdy);
         @(posedge i_clk);
         #1;
         check($sformatf("vec%0d_count", i), 32'(bus.o_count), 32'(vecs[i].cnt));
         check($sformatf("vec%0d_valid", i), 32'(bus.o_dout_valid), 32'(vecs[i].vld));
         check($sformatf("vec%0d_ready", i), 32'(bus.o_ready), 32'(vecs[i].rdy_o));
         if (vecs[i].chk_dout)
            check($sformatf("vec%0d_dout", i), 32'(bus.ov_dout), 32'(vecs[i].dout));
      end

      // Fill to full, offer a 17th word, then drain in order
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, DW'(i + 1), 1'b0);
      check("full_count", 32'(bus.o_count), 32'(DEPTH));
      check("full_af", 32'(bus.o_almost_full), 32'd1);
      cyc(1'b1, 1'b1, 24'h0000FF, 1'b0);
      check("full_reject", 32'(bus.o_count), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, '0, 1'b1);
      check("drain_len", 32'(out_log.size()), 32'(DEPTH));
      for (int i = 0; i < out_log.size(); i++)
         check($sformatf("drain_%0d", i), 32'(out_log[i]), 32'(i + 1));

      // Full plus simultaneous read: count drops, pending word enters next cycle
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b1, DW'(24'h100 + i), 1'b0);
      cyc(1'b1, 1'b1, 24'h0000FF, 1'b1);
      check("fullrd_count", 32'(bus.o_count), 32'(DEPTH - 1));
      check("fullrd_ready", 32'(bus.o_ready), 32'd1);
      cyc(1'b1, 1'b1, 24'h0000FF, 1'b0);
      check("fullrd_refill", 32'(bus.o_count), 32'(DEPTH));
      out_log.delete();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, '0, 1'b1);
      check("fullrd_last", 32'(out_log[DEPTH-1]), 32'h0000FF);

      // Streaming wrap: 40 words in, ready pattern 1-0-1-1
      do_reset();
      begin
         int next_word = 1;
         int cyc_n     = 0;
         logic rdy_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
         while (out_log.size() < 40 && cyc_n < 300) begin
            cyc(1'b1, next_word <= 40, DW'(next_word), rdy_pat[cyc_n % 4]);
            if (next_word <= 40 && model_q.size() > 0 && model_q[model_q.size()-1] == DW'(next_word))
               next_word++;
            check("stream_le_depth", 32'(bus.o_count <= DEPTH), 32'd1);
            cyc_n++;
         end
         check("stream_done", 32'(out_log.size()), 32'd40);
         for (int i = 0; i < out_log.size(); i++)
            check($sformatf("stream_%0d", i), 32'(out_log[i]), 32'(i + 1));
      end

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++)
         cyc($urandom_range(0, 9) != 0, 1'($urandom), DW'($urandom), 1'($urandom));

      // Enable freeze with 5 held, then asynchronous reset mid-cycle
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, DW'(24'h500 + i), 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 24'hDEAD00, 1'b1);
      check("freeze_count", 32'(bus.o_count), 32'd5);
      cyc(1'b1, 1'b0, '0, 1'b0);
      check("resume_dout", 32'(bus.ov_dout), 32'h000500);
      check("resume_valid", 32'(bus.o_dout_valid), 32'd1);
      #3;
      i_rst = 1'b1;
      #1;
      check("async_rst_count", 32'(bus.o_count), 32'd0);
      check("async_rst_valid", 32'(bus.o_dout_valid), 32'd0);
      check("async_rst_ready", 32'(bus.o_ready), 32'd0);
      @(posedge i_clk);
      #2;
      i_rst = 1'b0;
      model_q.delete();
      cyc(1'b1, 1'b0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
